modrm_sib_decoder: RTL and testbench

- Sequential producer for the address generate unit in the decode unit.
- Consumes instruction bytes one per cycle from the prefetch byte stream: the mod r/m byte, an optional s-i-b byte, then 0/1/2/4 little-endian displacement bytes.
- Emits a registered, handshaked effective-address descriptor: base/index register selects, one-hot scale, sign-extended 32-bit displacement, and the default segment (segment_DS/segment_SS) consumed by the AGU.
- Supports both 16-bit and 32-bit addressing.

---
 rtl/decode_pkg.sv | 62 ++++++
 rtl/disp_assembler.sv | 38 +++
 rtl/modrm_sib_decoder.sv | 179 +++++++++++++++++
 tb/tb_modrm_sib_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the mod r/m / s-i-b decoder.
package decode_pkg;

  typedef logic [2:0] reg_t;

  localparam reg_t REG_EAX = 3'd0;
  localparam reg_t REG_ECX = 3'd1;
  localparam reg_t REG_EDX = 3'd2;
  localparam reg_t REG_EBX = 3'd3;
  localparam reg_t REG_ESP = 3'd4;
  localparam reg_t REG_EBP = 3'd5;
  localparam reg_t REG_ESI = 3'd6;
  localparam reg_t REG_EDI = 3'd7;

  localparam logic [1:0] MOD_MEM       = 2'b00;
  localparam logic [1:0] MOD_DISP8     = 2'b01;
  localparam logic [1:0] MOD_DISP16_32 = 2'b10;
  localparam logic [1:0] MOD_REG       = 2'b11;

  // 3'b100 is both "SIB follows" in rm and "no index" in the SIB index field.
  localparam logic [2:0] CODE_SIB_NO_INDEX = 3'b100;
  localparam logic [2:0] CODE_DISP32       = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODRM,
    ST_SIB,
    ST_DISP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] reg_field;
    logic       rm_is_register;
    reg_t       rm_reg;
    logic       base_valid;
    reg_t       base_reg;
    logic       index_valid;
    reg_t       index_reg;
    logic [1:0] scale;
    logic       seg_ds;
    logic       seg_ss;
    logic [2:0] length;
    logic [2:0] disp_n;
    logic [1:0] mod;
  } desc_t;

  // Stack-relative bases default to SS; BP shares code 5 with EBP.
  function automatic logic base_uses_ss(input logic valid, input reg_t base);
    return valid && (base == REG_ESP || base == REG_EBP);
  endfunction

  // Displacement byte count implied by mod under 32-bit addressing.
  function automatic logic [2:0] disp_count32(input logic [1:0] mod);
    case (mod)
      MOD_DISP8:     return 3'd1;
      MOD_DISP16_32: return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/disp_assembler.sv
// Little-endian displacement collector with sign extension chosen by byte count.
module disp_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  input  logic [2:0]  count,
  output logic [31:0] value,
  output logic        last
);

  logic [31:0] raw;
  logic [1:0]  idx;

  // Drop each accepted byte into the next byte lane.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      raw <= '0;
      idx <= '0;
    end else if (load) begin
      raw[{idx, 3'b000} +: 8] <= data;
      idx <= idx + 2'd1;
    end
  end

  // Flags the byte lane that completes the displacement, and sign-extends the result.
  always_comb begin
    last = (({1'b0, idx} + 3'd1) == count);
    case (count)
      3'd1:    value = {{24{raw[7]}}, raw[7:0]};
      3'd2:    value = {{16{raw[15]}}, raw[15:0]};
      3'd4:    value = raw;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/modrm_sib_decoder.sv
// Mod r/m + s-i-b byte decoder producing an effective-address descriptor for the AGU.
module modrm_sib_decoder
  import decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  output logic        start_ready,
  input  logic        address_size_32,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  reg_field,
  output logic        rm_is_register,
  output logic [2:0]  rm_reg,
  output logic        base_valid,
  output logic [2:0]  base_reg,
  output logic        index_valid,
  output logic [2:0]  index_reg,
  output logic        scale_x1,
  output logic        scale_x2,
  output logic        scale_x4,
  output logic        scale_x8,
  output logic [31:0] displacement,
  output logic        segment_DS,
  output logic        segment_SS,
  output logic [2:0]  modrm_length
);

  state_t     state, state_next;
  desc_t      desc, desc_next;
  logic       addr32;
  logic       asm_clear, asm_load, asm_last;
  logic [1:0] f_hi;
  logic [2:0] f_mid, f_low;

  assign f_hi  = in_data[7:6];
  assign f_mid = in_data[5:3];
  assign f_low = in_data[2:0];

  // State, descriptor and address-size registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      desc   <= '0;
      addr32 <= 1'b0;
    end else begin
      state <= state_next;
      desc  <= desc_next;
      if (state == ST_IDLE && start && !flush) addr32 <= address_size_32;
    end
  end

  // Next-state and descriptor decode; one byte is consumed per in_valid cycle.
  always_comb begin
    state_next = state;
    desc_next  = desc;
    asm_clear  = 1'b0;
    asm_load   = 1'b0;
    if (flush) begin
      state_next = ST_IDLE;
      desc_next  = '0;
      asm_clear  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_next = ST_MODRM;
          desc_next  = '0;
          asm_clear  = 1'b1;
        end
        ST_MODRM: if (in_valid) begin
          desc_next.reg_field = f_mid;
          desc_next.mod       = f_hi;
          desc_next.length    = 3'd1;
          if (f_hi == MOD_REG) begin
            desc_next.rm_is_register = 1'b1;
            desc_next.rm_reg         = f_low;
          end else if (addr32) begin
            if (f_low != CODE_SIB_NO_INDEX) begin
              if (f_hi == MOD_MEM && f_low == CODE_DISP32) begin
                desc_next.disp_n = 3'd4;
              end else begin
                desc_next.base_valid = 1'b1;
                desc_next.base_reg   = f_low;
                desc_next.disp_n     = disp_count32(f_hi);
              end
            end
          end else begin
            case (f_low)
              3'b000: begin desc_next.base_valid = 1'b1; desc_next.base_reg = REG_EBX;
                            desc_next.index_valid = 1'b1; desc_next.index_reg = REG_ESI; end
              3'b001: begin desc_next.base_valid = 1'b1; desc_next.base_reg = REG_EBX;
                            desc_next.index_valid = 1'b1; desc_next.index_reg = REG_EDI; end
              3'b010: begin desc_next.base_valid = 1'b1; desc_next.base_reg = REG_EBP;
                            desc_next.index_valid = 1'b1; desc_next.index_reg = REG_ESI; end
              3'b011: begin desc_next.base_valid = 1'b1; desc_next.base_reg = REG_EBP;
                            desc_next.index_valid = 1'b1; desc_next.index_reg = REG_EDI; end
              3'b100: begin desc_next.index_valid = 1'b1; desc_next.index_reg = REG_ESI; end
              3'b101: begin desc_next.index_valid = 1'b1; desc_next.index_reg = REG_EDI; end
              3'b110: if (f_hi != MOD_MEM) begin
                desc_next.base_valid = 1'b1;
                desc_next.base_reg   = REG_EBP;
              end
              default: begin desc_next.base_valid = 1'b1; desc_next.base_reg = REG_EBX; end
            endcase
            if (f_hi == MOD_DISP8)                          desc_next.disp_n = 3'd1;
            else if (f_hi == MOD_DISP16_32)                 desc_next.disp_n = 3'd2;
            else if (f_hi == MOD_MEM && f_low == 3'b110)    desc_next.disp_n = 3'd2;
          end
          if (f_hi != MOD_REG) begin
            desc_next.seg_ss = base_uses_ss(desc_next.base_valid, desc_next.base_reg);
            desc_next.seg_ds = !desc_next.seg_ss;
          end
          if (addr32 && f_hi != MOD_REG && f_low == CODE_SIB_NO_INDEX) state_next = ST_SIB;
          else if (desc_next.disp_n != 3'd0)                          state_next = ST_DISP;
          else                                                        state_next = ST_DONE;
        end
        ST_SIB: if (in_valid) begin
          desc_next.scale  = f_hi;
          desc_next.length = 3'd2;
          if (f_mid != CODE_SIB_NO_INDEX) begin
            desc_next.index_valid = 1'b1;
            desc_next.index_reg   = f_mid;
          end
          if (f_low == CODE_DISP32 && desc.mod == MOD_MEM) begin
            desc_next.disp_n = 3'd4;
          end else begin
            desc_next.base_valid = 1'b1;
            desc_next.base_reg   = f_low;
            desc_next.disp_n     = disp_count32(desc.mod);
          end
          desc_next.seg_ss = base_uses_ss(desc_next.base_valid, desc_next.base_reg);
          desc_next.seg_ds = !desc_next.seg_ss;
          state_next = (desc_next.disp_n != 3'd0) ? ST_DISP : ST_DONE;
        end
        ST_DISP: if (in_valid) begin
          asm_load         = 1'b1;
          desc_next.length = desc.length + 3'd1;
          if (asm_last) state_next = ST_DONE;
        end
        ST_DONE: if (out_ready) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  disp_assembler u_disp (
    .clock (clock),
    .reset (reset),
    .clear (asm_clear),
    .load  (asm_load),
    .data  (in_data),
    .count (desc.disp_n),
    .value (displacement),
    .last  (asm_last)
  );

  assign start_ready    = (state == ST_IDLE);
  assign in_ready       = (state == ST_MODRM) || (state == ST_SIB) || (state == ST_DISP);
  assign out_valid      = (state == ST_DONE);
  assign reg_field      = desc.reg_field;
  assign rm_is_register = desc.rm_is_register;
  assign rm_reg         = desc.rm_reg;
  assign base_valid     = desc.base_valid;
  assign base_reg       = desc.base_reg;
  assign index_valid    = desc.index_valid;
  assign index_reg      = desc.index_reg;
  assign scale_x1       = (desc.scale == 2'd0);
  assign scale_x2       = (desc.scale == 2'd1);
  assign scale_x4       = (desc.scale == 2'd2);
  assign scale_x8       = (desc.scale == 2'd3);
  assign segment_DS     = desc.seg_ds;
  assign segment_SS     = desc.seg_ss;
  assign modrm_length   = desc.length;

endmodule

// File: tb/tb_modrm_sib_decoder.sv
// Directed scoreboard bench for modrm_sib_decoder.
module tb_modrm_sib_decoder;

  logic        clock, reset, flush, start, start_ready, address_size_32;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [2:0]  reg_field, rm_reg, base_reg, index_reg, modrm_length;
  logic        rm_is_register, base_valid, index_valid;
  logic        scale_x1, scale_x2, scale_x4, scale_x8, segment_DS, segment_SS;
  logic [31:0] displacement;

  typedef struct {
    logic [2:0]  reg_field;
    logic        rm_is_register;
    logic [2:0]  rm_reg;
    logic        base_valid;
    logic [2:0]  base_reg;
    logic        index_valid;
    logic [2:0]  index_reg;
    logic [3:0]  scale;
    logic [31:0] disp;
    logic        ds;
    logic        ss;
    logic [2:0]  len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;

  modrm_sib_decoder dut (
    .clock(clock), .reset(reset), .flush(flush), .start(start), .start_ready(start_ready),
    .address_size_32(address_size_32), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .reg_field(reg_field), .rm_is_register(rm_is_register), .rm_reg(rm_reg),
    .base_valid(base_valid), .base_reg(base_reg), .index_valid(index_valid),
    .index_reg(index_reg), .scale_x1(scale_x1), .scale_x2(scale_x2), .scale_x4(scale_x4),
    .scale_x8(scale_x8), .displacement(displacement), .segment_DS(segment_DS),
    .segment_SS(segment_SS), .modrm_length(modrm_length)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] rf, input logic isreg, input logic [2:0] rr,
                          input logic bv, input logic [2:0] br, input logic iv,
                          input logic [2:0] ir, input logic [3:0] sc, input logic [31:0] d,
                          input logic ds, input logic ss, input logic [2:0] len);
    exp_t e;
    e.reg_field = rf; e.rm_is_register = isreg; e.rm_reg = rr;
    e.base_valid = bv; e.base_reg = br; e.index_valid = iv; e.index_reg = ir;
    e.scale = sc; e.disp = d; e.ds = ds; e.ss = ss; e.len = len;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_decode(input string tag, input logic a32);
    address_size_32 = a32;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".in_ready_after_start"}, in_ready, 1);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
    logic rdy, accepted;
    accepted = 1'b0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check({tag, ".byte_accepted"}, accepted, 1);
  endtask

  // Feeds the queued bytes, then checks out_valid rises right after the last byte.
  task automatic run(input string tag, input logic a32, input int gap);
    begin_decode(tag, a32);
    for (int i = 0; i < stim.size(); i++) send_byte(tag, stim[i], (i > 0) ? gap : 0);
    stim.delete();
    check({tag, ".out_valid_latency"}, out_valid, 1);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
  endtask

  task automatic compare_desc(input string tag);
    exp_t e;
    check({tag, ".sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".out_valid"}, out_valid, 1);
      check({tag, ".reg_field"}, reg_field, e.reg_field);
      check({tag, ".rm_is_register"}, rm_is_register, e.rm_is_register);
      check({tag, ".rm_reg"}, rm_reg, e.rm_reg);
      check({tag, ".base_valid"}, base_valid, e.base_valid);
      check({tag, ".base_reg"}, base_reg, e.base_reg);
      check({tag, ".index_valid"}, index_valid, e.index_valid);
      check({tag, ".index_reg"}, index_reg, e.index_reg);
      check({tag, ".scale"}, {scale_x8, scale_x4, scale_x2, scale_x1}, e.scale);
      check({tag, ".displacement"}, displacement, e.disp);
      check({tag, ".segment_DS"}, segment_DS, e.ds);
      check({tag, ".segment_SS"}, segment_SS, e.ss);
      check({tag, ".modrm_length"}, modrm_length, e.len);
    end
  endtask

  task automatic release_desc(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, out_valid, 0);
    check({tag, ".start_ready_back"}, start_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".start_ready"}, start_ready, 1);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".reg_field"}, reg_field, 0);
    check({tag, ".rm_is_register"}, rm_is_register, 0);
    check({tag, ".base_valid"}, base_valid, 0);
    check({tag, ".base_reg"}, base_reg, 0);
    check({tag, ".index_valid"}, index_valid, 0);
    check({tag, ".scale"}, {scale_x8, scale_x4, scale_x2, scale_x1}, 4'b0001);
    check({tag, ".displacement"}, displacement, 0);
    check({tag, ".segments"}, {segment_DS, segment_SS}, 2'b00);
    check({tag, ".modrm_length"}, modrm_length, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; start = 1'b0; address_size_32 = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_state("reset");

    // 16-bit [BX+SI]
    stim = '{8'h00};
    push_exp(3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 3'd6, 4'b0001, 32'h0, 1'b1, 1'b0, 3'd1);
    run("bx_si", 1'b0, 0);
    compare_desc("bx_si");
    release_desc("bx_si");

    // 16-bit [BP+disp8], negative displacement
    stim = '{8'h46, 8'hFC};
    push_exp(3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 4'b0001, 32'hFFFFFFFC, 1'b0, 1'b1, 3'd2);
    run("bp_d8", 1'b0, 0);
    compare_desc("bp_d8");
    release_desc("bp_d8");

    // 32-bit [ESP] via SIB
    stim = '{8'h04, 8'h24};
    push_exp(3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 4'b0001, 32'h0, 1'b0, 1'b1, 3'd2);
    run("esp_sib", 1'b1, 0);
    compare_desc("esp_sib");
    release_desc("esp_sib");

    // 32-bit [EBP+ECX*4+disp32] with in_valid gaps
    stim = '{8'h84, 8'h8D, 8'h78, 8'h56, 8'h34, 8'h12};
    push_exp(3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd1, 4'b0100, 32'h12345678, 1'b0, 1'b1, 3'd6);
    run("sib_d32", 1'b1, 2);
    compare_desc("sib_d32");
    release_desc("sib_d32");

    // 32-bit absolute disp32, held with out_ready low for 3 cycles
    stim = '{8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_exp(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0001, 32'hDEADBEEF, 1'b1, 1'b0, 3'd5);
    run("abs32", 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abs32.hold_valid", out_valid, 1);
      check("abs32.hold_disp", displacement, 32'hDEADBEEF);
      check("abs32.hold_start_ready", start_ready, 0);
    end
    compare_desc("abs32");
    release_desc("abs32");

    // mod11 register operand
    stim = '{8'hC3};
    push_exp(3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0001, 32'h0, 1'b0, 1'b0, 3'd1);
    run("mod11", 1'b1, 0);
    compare_desc("mod11");
    release_desc("mod11");

    // flush during the second displacement byte
    begin_decode("flush", 1'b1);
    send_byte("flush", 8'h05, 0);
    send_byte("flush", 8'hEF, 0);
    in_valid = 1'b1;
    in_data  = 8'hBE;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush.out_valid", out_valid, 0);
    check("flush.start_ready", start_ready, 1);
    check("flush.in_ready", in_ready, 0);

    // 16-bit [BP+disp16] after the flush
    stim = '{8'h86, 8'h34, 8'h12};
    push_exp(3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 4'b0001, 32'h00001234, 1'b0, 1'b1, 3'd3);
    run("bp_d16", 1'b0, 1);
    compare_desc("bp_d16");
    release_desc("bp_d16");

    // 16-bit disp16-only, sign bit set, reg field 7
    stim = '{8'h3E, 8'h00, 8'h80};
    push_exp(3'd7, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'b0001, 32'hFFFF8000, 1'b1, 1'b0, 3'd3);
    run("abs16", 1'b0, 0);
    compare_desc("abs16");
    release_desc("abs16");

    // reset while waiting for the SIB byte
    begin_decode("rst_sib", 1'b1);
    send_byte("rst_sib", 8'h3C, 0);
    check("rst_sib.in_sib", in_ready, 1);
    check("rst_sib.reg_field_latched", reg_field, 3'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_sib");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
